// File: rtl/switch_debounce8.sv
// Purpose : eight-channel switch conditioner: 2-FF synchroniser, shared tick prescaler, per-bit debounce.
// Latency : clean step reaches outN after 2 + (1..PRESCALE) + (STABLE_TICKS-1)*PRESCALE cycles.
// Backpr. : none; inputs are free-running levels and outputs are registered levels plus a strobe.
//
// Ports:
//   clk        system clock, rising edge
//   rst_n      asynchronous active-low reset
//   in0..in7   raw asynchronous switch inputs
//   out0..out7 synchronised, debounced levels (reset to RESET_VAL bit i)
//   changed    one-cycle pulse in the cycle any out bit takes a new value

module switch_debounce8 #(
    parameter int unsigned PRESCALE     = 100000,
    parameter int unsigned STABLE_TICKS = 10,
    parameter logic [7:0]  RESET_VAL    = 8'h00
) (
    input  logic clk,
    input  logic rst_n,
    input  logic in0,
    input  logic in1,
    input  logic in2,
    input  logic in3,
    input  logic in4,
    input  logic in5,
    input  logic in6,
    input  logic in7,
    output logic out0,
    output logic out1,
    output logic out2,
    output logic out3,
    output logic out4,
    output logic out5,
    output logic out6,
    output logic out7,
    output logic changed
);

    // A prescaler of 1 still needs a 1-bit counter (it simply stays at 0).
    localparam int unsigned   PW   = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int unsigned   CW   = $clog2(STABLE_TICKS + 1);
    localparam logic [PW-1:0] PMAX = PW'(PRESCALE - 1);
    localparam logic [CW-1:0] CMAX = CW'(STABLE_TICKS - 1);

    logic [7:0]    raw;
    logic [7:0]    sync1;
    logic [7:0]    sync2;
    logic [7:0]    out_q;
    logic [7:0]    flip;
    logic [PW-1:0] pcnt;
    logic          tick;
    logic [CW-1:0] cnt [8];
    logic          changed_q;

    assign raw = {in7, in6, in5, in4, in3, in2, in1, in0};

    // Synchroniser stages reset to the output reset level so a switch already
    // sitting at its reset position never looks like a pending change.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= RESET_VAL;
            sync2 <= RESET_VAL;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pcnt <= '0;
        end else if (pcnt == PMAX) begin
            pcnt <= '0;
        end else begin
            pcnt <= pcnt + 1'b1;
        end
    end

    assign tick = (pcnt == PMAX);

    // A bit flips on the tick where its counter has already seen
    // STABLE_TICKS-1 qualifying ticks; that tick is the final one.
    always_comb begin
        flip = '0;
        for (int i = 0; i < 8; i++) begin
            flip[i] = tick && (sync2[i] != out_q[i]) && (cnt[i] == CMAX);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_q     <= RESET_VAL;
            changed_q <= 1'b0;
            for (int i = 0; i < 8; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            out_q     <= out_q ^ flip;
            changed_q <= |flip;
            for (int i = 0; i < 8; i++) begin
                // Agreement on any cycle (tick or not) restarts the bit.
                if ((sync2[i] == out_q[i]) || flip[i]) begin
                    cnt[i] <= '0;
                end else if (tick) begin
                    cnt[i] <= cnt[i] + 1'b1;
                end
            end
        end
    end

    assign out0    = out_q[0];
    assign out1    = out_q[1];
    assign out2    = out_q[2];
    assign out3    = out_q[3];
    assign out4    = out_q[4];
    assign out5    = out_q[5];
    assign out6    = out_q[6];
    assign out7    = out_q[7];
    assign changed = changed_q;

endmodule

// File: tb/tb_switch_debounce8.sv
// Purpose : bench for switch_debounce8; instance a (PRESCALE=4, STABLE_TICKS=3, RESET_VAL=00), instance b (1, 1, A5).
// Latency : n/a.
// Backpr. : n/a.

module tb_switch_debounce8;

    localparam int         PA  = 4;
    localparam int         STA = 3;
    localparam logic [7:0] RVA = 8'h00;
    localparam int         PB  = 1;
    localparam int         STB = 1;
    localparam logic [7:0] RVB = 8'hA5;

    logic       clk  = 1'b0;
    logic [1:0] rstn = 2'b00;
    logic [7:0] in_a = RVA;
    logic [7:0] in_b = RVB;
    logic [7:0] out_a;
    logic [7:0] out_b;
    logic       chg_a;
    logic       chg_b;

    int checks = 0;
    int errors = 0;
    int edges  = 0;
    int st_edge;

    always #5 clk = ~clk;
    always @(posedge clk) edges++;

    switch_debounce8 #(.PRESCALE(PA), .STABLE_TICKS(STA), .RESET_VAL(RVA)) dut_a (
        .clk(clk), .rst_n(rstn[0]),
        .in0(in_a[0]), .in1(in_a[1]), .in2(in_a[2]), .in3(in_a[3]),
        .in4(in_a[4]), .in5(in_a[5]), .in6(in_a[6]), .in7(in_a[7]),
        .out0(out_a[0]), .out1(out_a[1]), .out2(out_a[2]), .out3(out_a[3]),
        .out4(out_a[4]), .out5(out_a[5]), .out6(out_a[6]), .out7(out_a[7]),
        .changed(chg_a)
    );

    switch_debounce8 #(.PRESCALE(PB), .STABLE_TICKS(STB), .RESET_VAL(RVB)) dut_b (
        .clk(clk), .rst_n(rstn[1]),
        .in0(in_b[0]), .in1(in_b[1]), .in2(in_b[2]), .in3(in_b[3]),
        .in4(in_b[4]), .in5(in_b[5]), .in6(in_b[6]), .in7(in_b[7]),
        .out0(out_b[0]), .out1(out_b[1]), .out2(out_b[2]), .out3(out_b[3]),
        .out4(out_b[4]), .out5(out_b[5]), .out6(out_b[6]), .out7(out_b[7]),
        .changed(chg_b)
    );

    // ---------------- reference model ----------------
    // A bit flips on a tick once it has disagreed with its output for every
    // cycle of a window holding STABLE_TICKS ticks, i.e. (ST-1)*P+1 cycles.
    logic [7:0] m_s1  [2];
    logic [7:0] m_s2  [2];
    logic [7:0] m_out [2];
    logic       m_chg [2];
    int         m_run [2][8];
    int         m_cyc [2];

    task automatic model_step(input int k);
        int         p;
        int         st;
        int         need;
        logic       tick;
        logic [7:0] flips;
        logic [7:0] rv;
        p  = (k == 0) ? PA : PB;
        st = (k == 0) ? STA : STB;
        rv = (k == 0) ? RVA : RVB;
        if (!rstn[k]) begin
            m_s1[k]  = rv;
            m_s2[k]  = rv;
            m_out[k] = rv;
            m_chg[k] = 1'b0;
            m_cyc[k] = 0;
            for (int i = 0; i < 8; i++) m_run[k][i] = 0;
        end else begin
            tick  = ((m_cyc[k] % p) == p - 1);
            need  = (st - 1) * p + 1;
            flips = '0;
            for (int i = 0; i < 8; i++) begin
                if (m_s2[k][i] != m_out[k][i]) begin
                    m_run[k][i] = m_run[k][i] + 1;
                    if (tick && m_run[k][i] >= need) begin
                        flips[i]    = 1'b1;
                        m_run[k][i] = 0;
                    end
                end else begin
                    m_run[k][i] = 0;
                end
            end
            m_out[k] = m_out[k] ^ flips;
            m_chg[k] = |flips;
            m_s2[k]  = m_s1[k];
            m_s1[k]  = (k == 0) ? in_a : in_b;
            m_cyc[k] = m_cyc[k] + 1;
        end
    endtask

    always @(posedge clk or negedge rstn[0]) model_step(0);
    always @(posedge clk or negedge rstn[1]) model_step(1);

    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            logic [7:0] o;
            logic       c;
            o = (k == 0) ? out_a : out_b;
            c = (k == 0) ? chg_a : chg_b;
            checks++;
            if (o !== m_out[k] || c !== m_chg[k]) begin
                errors++;
                $display("FAIL model_cmp inst%0d edge %0d: out=%h changed=%b, expected out=%h changed=%b",
                         k, edges, o, c, m_out[k], m_chg[k]);
            end
        end
    end

    // ---------------- directed helpers ----------------
    int         w_trans [8];
    int         w_first [8];
    int         w_chg;
    int         w_bad;
    logic [7:0] w_prev;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic chk_rng(input string name, input int act, input int lo, input int hi);
        checks++;
        if (act < lo || act > hi) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
        end
    endtask

    task automatic clear_watch(input int k);
        for (int i = 0; i < 8; i++) begin
            w_trans[i] = 0;
            w_first[i] = -1;
        end
        w_chg  = 0;
        w_bad  = 0;
        w_prev = (k == 0) ? out_a : out_b;
    endtask

    // Samples n cycles at the falling edge, logging per-bit transitions,
    // changed pulses, and cycles where changed disagrees with an update.
    task automatic watch(input int k, input int n);
        logic [7:0] cur;
        logic [7:0] diff;
        logic       ch;
        for (int c = 0; c < n; c++) begin
            @(negedge clk);
            cur  = (k == 0) ? out_a : out_b;
            ch   = (k == 0) ? chg_a : chg_b;
            diff = cur ^ w_prev;
            for (int i = 0; i < 8; i++) begin
                if (diff[i]) begin
                    if (w_trans[i] == 0) w_first[i] = edges;
                    w_trans[i]++;
                end
            end
            if (ch === 1'b1) w_chg++;
            if (ch !== (diff != 8'h00)) w_bad++;
            w_prev = cur;
        end
    endtask

    task automatic drive(input int k, input logic [7:0] v);
        @(posedge clk);
        #1;
        if (k == 0) in_a = v;
        else        in_b = v;
        st_edge = edges;
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int rel;
        repeat (3) @(posedge clk);
        #1;
        chk("reset out_a", int'(out_a), 8'h00);
        chk("reset chg_a", int'(chg_a), 0);
        chk("reset out_b", int'(out_b), 8'hA5);
        chk("reset chg_b", int'(chg_b), 0);
        @(posedge clk);
        #1;
        rstn = 2'b11;
        rel  = edges;

        // 1. clean step on in3 at cycle 10
        clear_watch(0);
        watch(0, 10);
        drive(0, 8'h08);
        watch(0, 20);
        chk_rng("t1 rise cycle", w_first[3] - rel, 21, 24);
        chk("t1 out3 transitions", w_trans[3], 1);
        chk("t1 changed pulses", w_chg, 1);
        chk("t1 changed align", w_bad, 0);
        chk("t1 out_a", int'(out_a), 8'h08);
        clear_watch(0);
        drive(0, 8'h00);
        watch(0, 20);
        chk_rng("t1 fall latency", w_first[3] - st_edge, 11, 14);
        chk("t1 fall changed", w_chg, 1);
        chk("t1 out_a after fall", int'(out_a), 8'h00);

        // 2. 5-cycle glitch on in5
        clear_watch(0);
        drive(0, 8'h20);
        watch(0, 5);
        drive(0, 8'h00);
        watch(0, 40);
        chk("t2 out5 transitions", w_trans[5], 0);
        chk("t2 changed pulses", w_chg, 0);

        // 3. bounce on in1, then settle high
        clear_watch(0);
        for (int s = 0; s < 10; s++) begin
            drive(0, (s % 2 == 0) ? 8'h02 : 8'h00);
            watch(0, 2);
        end
        drive(0, 8'h02);
        watch(0, 20);
        chk("t3 out1 transitions", w_trans[1], 1);
        chk_rng("t3 settle latency", w_first[1] - st_edge, 11, 14);
        chk("t3 changed pulses", w_chg, 1);
        chk("t3 changed align", w_bad, 0);

        // 4. in0 and in7 rise together
        clear_watch(0);
        drive(0, 8'h83);
        watch(0, 20);
        chk("t4 out0 transitions", w_trans[0], 1);
        chk("t4 out7 transitions", w_trans[7], 1);
        chk("t4 same cycle", w_first[7] - w_first[0], 0);
        chk("t4 changed pulses", w_chg, 1);
        chk("t4 out_a", int'(out_a), 8'h83);

        // 5. reset while in2 is counting
        clear_watch(0);
        drive(0, 8'h87);
        watch(0, 8);
        chk("t5 out2 before reset", int'(out_a[2]), 0);
        @(posedge clk);
        #1;
        rstn[0] = 1'b0;
        #1;
        chk("t5 out_a in reset", int'(out_a), 8'h00);
        chk("t5 chg_a in reset", int'(chg_a), 0);
        repeat (3) @(posedge clk);
        #1;
        rstn[0] = 1'b1;
        rel = edges;
        clear_watch(0);
        watch(0, 20);
        chk("t5 out2 transitions", w_trans[2], 1);
        chk_rng("t5 rise after release", w_first[2] - rel, 11, 14);
        chk("t5 changed pulses", w_chg, 1);

        // 6. degenerate instance: step on in1 lands exactly 3 cycles later
        clear_watch(1);
        drive(1, 8'hA7);
        watch(1, 6);
        chk("t6 out1 latency", w_first[1] - st_edge, 3);
        chk("t6 out1 transitions", w_trans[1], 1);
        chk("t6 changed pulses", w_chg, 1);
        chk("t6 changed align", w_bad, 0);
        chk("t6 out_b", int'(out_b), 8'hA7);

        @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
